// File: rtl/debounce_scanner.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scanner
// Purpose  : Time-multiplexed button debouncer. One shared shift/compare
//            engine scans N_CH synchronized inputs round-robin, one channel
//            per scan step, and reports level changes as press/release events
//            through a single-entry valid/ready output register.
// Revision : 1.0  initial release
// ============================================================================
module debounce_scanner #(
  parameter int N_CH     = 4,
  parameter int HIST_LEN = 8,
  parameter int TICK_DIV = 16,
  parameter int CH_W     = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] debounced,
  output logic            event_valid,
  output logic [CH_W-1:0] event_ch,
  output logic            event_press,
  input  logic            event_ready,
  output logic            overflow
);

  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  logic [N_CH-1:0]                sync1_q;
  logic [N_CH-1:0]                sync2_q;
  logic [DIV_W-1:0]               div_q;
  logic [CH_W-1:0]                ch_q;
  logic [N_CH-1:0][HIST_LEN-1:0]  hist_q;
  logic [N_CH-1:0]                debounced_q;
  logic                           ev_valid_q;
  logic [CH_W-1:0]                ev_ch_q;
  logic                           ev_press_q;
  logic                           overflow_q;

  logic                           step;
  logic [HIST_LEN-1:0]            h_next;
  logic                           is_press;
  logic                           is_release;
  logic                           new_event;

  // Scan strobe, shifted history of the scanned channel and event detection.
  always_comb begin
    step       = (div_q == DIV_LAST);
    h_next     = {hist_q[ch_q][HIST_LEN-2:0], sync2_q[ch_q]};
    is_press   = step && (&h_next)  && !debounced_q[ch_q];
    is_release = step && !(|h_next) &&  debounced_q[ch_q];
    new_event  = is_press || is_release;
  end

  // Two-flop synchronizer on the raw, asynchronous button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  // Clock divider producing one scan step every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (step) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Round-robin channel pointer; explicit wrap handles non-power-of-two N_CH.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q <= '0;
    end else if (step) begin
      ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    end
  end

  // History shift and debounced-level update for the scanned channel only.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q      <= '0;
      debounced_q <= '0;
    end else if (step) begin
      hist_q[ch_q] <= h_next;
      if (is_press) begin
        debounced_q[ch_q] <= 1'b1;
      end else if (is_release) begin
        debounced_q[ch_q] <= 1'b0;
      end
    end
  end

  // Single-entry event register; a new event that finds it occupied and not
  // draining is dropped and flagged with a one-cycle overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_press_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (new_event) begin
        if (!ev_valid_q || event_ready) begin
          ev_valid_q <= 1'b1;
          ev_ch_q    <= ch_q;
          ev_press_q <= is_press;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (ev_valid_q && event_ready) begin
        ev_valid_q <= 1'b0;
      end
    end
  end

  assign debounced   = debounced_q;
  assign event_valid = ev_valid_q;
  assign event_ch    = ev_ch_q;
  assign event_press = ev_press_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_scanner
// Purpose  : Directed self-checking bench for debounce_scanner
//            (N_CH=4, HIST_LEN=8, TICK_DIV=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_debounce_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'b0000;
  logic [3:0] debounced;
  logic       event_valid;
  logic [1:0] event_ch;
  logic       event_press;
  logic       event_ready = 1'b0;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  debounce_scanner #(.N_CH(4), .HIST_LEN(8), .TICK_DIV(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .debounced  (debounced),
    .event_valid(event_valid),
    .event_ch   (event_ch),
    .event_press(event_press),
    .event_ready(event_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; afterwards we sit 1 ns into the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  // Reset for two cycles; the cycle in which reset drops is cycle 0.
  task automatic do_reset(input logic [3:0] b, input logic rdy);
    reset = 1'b1;
    tick();
    tick();
    reset       = 1'b0;
    buttons     = b;
    event_ready = rdy;
    cyc         = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nvalid;
    int nov;
    logic seen;

    // 1. Reset values and idle behaviour
    do_reset(4'b0000, 1'b1);
    check("rst_debounced", debounced, 4'b0000);
    check("rst_valid", event_valid, 1'b0);
    check("rst_ch", event_ch, 2'd0);
    check("rst_press", event_press, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    seen = 1'b0;
    while (cyc < 2000) begin
      tick();
      if (event_valid || overflow || (debounced != 4'b0000)) seen = 1'b1;
    end
    check("idle_no_event", seen, 1'b0);

    // 2. Clean press and release on channel 2
    do_reset(4'b0100, 1'b1);
    goto(495);
    check("p2_before_deb", debounced, 4'b0000);
    check("p2_before_valid", event_valid, 1'b0);
    goto(496);
    check("p2_deb", debounced, 4'b0100);
    check("p2_valid", event_valid, 1'b1);
    check("p2_ch", event_ch, 2'd2);
    check("p2_press", event_press, 1'b1);
    goto(497);
    check("p2_drained", event_valid, 1'b0);
    buttons = 4'b0000;
    goto(1007);
    check("r2_before_deb", debounced, 4'b0100);
    check("r2_before_valid", event_valid, 1'b0);
    goto(1008);
    check("r2_deb", debounced, 4'b0000);
    check("r2_valid", event_valid, 1'b1);
    check("r2_ch", event_ch, 2'd2);
    check("r2_press", event_press, 1'b0);

    // 3. Bouncing channel 1, toggling every 40 cycles
    do_reset(4'b0010, 1'b1);
    seen = 1'b0;
    while (cyc < 2000) begin
      tick();
      if (cyc % 40 == 0) buttons[1] = ~buttons[1];
      if (event_valid || (debounced != 4'b0000)) seen = 1'b1;
    end
    check("bounce_no_change", seen, 1'b0);

    // 4. Backpressure: ch0 event held, ch1 event dropped
    do_reset(4'b0011, 1'b0);
    goto(464);
    check("bp_ch0_valid", event_valid, 1'b1);
    check("bp_ch0_ch", event_ch, 2'd0);
    check("bp_ch0_press", event_press, 1'b1);
    goto(479);
    check("bp_ov_early", overflow, 1'b0);
    check("bp_deb_early", debounced, 4'b0001);
    goto(480);
    check("bp_ov_pulse", overflow, 1'b1);
    check("bp_deb", debounced, 4'b0011);
    check("bp_held_ch", event_ch, 2'd0);
    check("bp_held_valid", event_valid, 1'b1);
    goto(481);
    check("bp_ov_end", overflow, 1'b0);
    goto(490);
    check("bp_hold_ch", event_ch, 2'd0);
    check("bp_hold_press", event_press, 1'b1);
    event_ready = 1'b1;
    goto(491);
    check("bp_transferred", event_valid, 1'b0);
    seen = 1'b0;
    while (cyc < 600) begin
      tick();
      if (event_valid || overflow) seen = 1'b1;
    end
    check("bp_only_one", seen, 1'b0);

    // 5. Back-to-back press/release on ch3 with ready held high
    do_reset(4'b1000, 1'b1);
    nvalid = 0;
    nov    = 0;
    while (cyc < 1100) begin
      tick();
      if (cyc == 513) buttons = 4'b0000;
      if (event_valid) nvalid++;
      if (overflow) nov++;
      if (cyc == 512) begin
        check("b2b_press_valid", event_valid, 1'b1);
        check("b2b_press_ch", event_ch, 2'd3);
        check("b2b_press_dir", event_press, 1'b1);
      end
      if (cyc == 1024) begin
        check("b2b_rel_valid", event_valid, 1'b1);
        check("b2b_rel_ch", event_ch, 2'd3);
        check("b2b_rel_dir", event_press, 1'b0);
        check("b2b_rel_deb", debounced, 4'b0000);
      end
    end
    check("b2b_valid_cycles", nvalid, 2);
    check("b2b_no_overflow", nov, 0);

    // 6. Reset with an event pending, then first step timing
    do_reset(4'b0100, 1'b0);
    goto(496);
    check("mid_pre_valid", event_valid, 1'b1);
    check("mid_pre_deb", debounced, 4'b0100);
    reset = 1'b1;
    tick();
    check("mid_rst_deb", debounced, 4'b0000);
    check("mid_rst_valid", event_valid, 1'b0);
    check("mid_rst_ch", event_ch, 2'd0);
    check("mid_rst_press", event_press, 1'b0);
    check("mid_rst_ov", overflow, 1'b0);
    reset       = 1'b0;
    buttons     = 4'b0001;
    event_ready = 1'b1;
    cyc         = 0;
    goto(463);
    check("mid_ch0_before", debounced, 4'b0000);
    goto(464);
    check("mid_ch0_deb", debounced, 4'b0001);
    check("mid_ch0_valid", event_valid, 1'b1);
    check("mid_ch0_ch", event_ch, 2'd0);
    check("mid_ch0_press", event_press, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounce_scanner.md
# debounce_scanner

Time-multiplexed debounce controller: one shared shift/compare engine serves `N_CH` raw button inputs in round-robin order, one channel per scan tick. It keeps a per-channel history register and a debounced-level vector. Each debounced level change is reported as a press/release event through a single-entry valid/ready output. It sits between the raw board buttons and the control logic that consumes button events, so a single debounce engine replaces per-button instances.

## Interface
- `N_CH`, default 4: number of button channels; must be ≥2.
- `HIST_LEN`, default 8: samples per channel that must agree before the level changes; must be ≥2.
- `TICK_DIV`, default 16: clock cycles per scan step; must be ≥1.
- `CH_W`, default `$clog2(N_CH)`: channel index width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `buttons`  in  N_CH  raw asynchronous button levels.
- `debounced`  out  N_CH  debounced level per channel.
- `event_valid`  out  1  an event is held in the output register.
- `event_ch`  out  CH_W  channel that produced the held event.
- `event_press`  out  1  1 = press (0→1), 0 = release (1→0).
- `event_ready`  in  1  consumer accepts the event.
- `overflow`  out  1  one-cycle pulse: an event was dropped.

## Operation
- **Synchronizer:** `buttons` passes through a 2-flop synchronizer per bit. The engine only ever sees `sync`, the second-stage output.
- **Divider:** `div` counts 0..TICK_DIV-1 and wraps. The step strobe is `div==TICK_DIV-1`; with TICK_DIV=1 it is high every cycle.
- **Channel pointer:** `ch` holds the channel sampled on a step, starting at 0. It advances by 1 on each step and wraps from N_CH-1 to 0.
- **On a step, for channel `ch`:**
  - `h_next = {hist[ch][HIST_LEN-2:0], sync[ch]}`; `hist[ch] <= h_next`.
  - If `h_next` is all ones and `debounced[ch]==0`: set `debounced[ch]` and generate a press event.
  - If `h_next` is all zeros and `debounced[ch]==1`: clear `debounced[ch]` and generate a release event.
  - Otherwise `debounced[ch]` is unchanged and no event is generated. A mixed history always holds the level.
- **Unscanned channels:** history and level do not change on steps for other channels or on non-step cycles.
- **Output register:**
  - A transfer occurs on any cycle with `event_valid && event_ready`.
  - New event, and the register is empty or transferring this cycle: load `event_ch`, `event_press`, and set `event_valid=1`.
  - New event while `event_valid && !event_ready`: the new event is dropped, `overflow` pulses high next cycle, and the held event is unchanged. The `debounced` update still happens.
  - Transfer with no new event: `event_valid` goes to 0.
  - While `event_valid=1` and `event_ready=0`, `event_ch` and `event_press` hold stable.
- **Reset**, applied at any time including mid-scan or with an event pending:
  - `div=0`, `ch=0`, synchronizer=0, all `hist`=0, `debounced=0`, `event_valid=0`, `event_ch=0`, `event_press=0`, `overflow=0`.
  - A pending event is discarded.

## Timing
- Cycle 0 is the first cycle with reset low. Step k occurs in cycle `k*TICK_DIV + TICK_DIV-1` and scans channel `k mod N_CH`.
- A given channel is sampled every `N_CH*TICK_DIV` cycles.
- Synchronizer latency is 2 cycles: a `buttons` change at the edge that starts cycle c is visible on `sync` in cycle c+2.
- `hist`, `debounced`, `event_*` and `overflow` are registered and update at the edge ending the step cycle, so they are visible in cycle step+1.
- Minimum latency from a stable input change to a `debounced` change is HIST_LEN samples of that channel.
- At most one event is generated per cycle, because only one channel is scanned per step; no arbitration is needed.
- `event_ready` may be held high continuously. It is sampled only when `event_valid=1`.

## Test plan
All scenarios use N_CH=4, HIST_LEN=8, TICK_DIV=16.

1. **Reset values:** after reset, every output is 0. Holding `event_ready=1` with `buttons=0` for 2000 cycles → no event, `debounced` stays 0.
2. **Clean press and release:**
   - `buttons[2]=1` from cycle 0 → channel 2's 8th high sample is at step 30 (cycle 495). In cycle 496, `debounced[2]=1`, `event_valid=1`, `event_ch=2`, `event_press=1`.
   - Release `buttons[2]` → release event after 8 more channel-2 samples.
3. **Bounce:** `buttons[1]` toggles every 40 cycles → `debounced[1]` never changes and no event is generated.
4. **Backpressure and overflow:**
   - `event_ready=0` while channels 0 and 1 both press → ch0's event is held.
   - ch1's event is dropped, with `overflow` high for exactly 1 cycle.
   - `debounced=4'b0011`.
   - Raising `event_ready` then transfers the ch0 event only.
5. **Back-to-back transfer:** with `event_ready=1` held, press ch3 then release it → exactly two events (press, then release), each with `event_valid` high for 1 cycle, and `overflow` never asserts.
6. **Reset mid-operation:** assert reset while `event_valid=1`, `debounced[2]=1`, `ch=3` → next cycle all outputs are 0. After release, the first step is in cycle 15 and scans ch0.
